// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - five-source CDB arbiter with per-source holding FIFOs and a registered broadcast
// Define CDB_STARVE_GUARD_EN to build the wait counters and starved-first grant.
module cdb_arbiter #(
  parameter int XLEN         = 32,
  parameter int TAG_W        = 4,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [4:0]          src_valid,
  output logic [4:0]          src_ready,
  input  logic [5*XLEN-1:0]   src_result,
  input  logic [5*TAG_W-1:0]  src_tag,
  output logic                cdb_valid,
  output logic [XLEN-1:0]     cdb_result,
  output logic [7:0]          cdb_tag,
  output logic [14:0]         fifo_count
);

  localparam int NSRC  = 5;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [CNT_W-1:0] count_q [NSRC];
  logic [CNT_W-1:0] count_d [NSRC];
  logic [PTR_W-1:0] wptr_q  [NSRC];
  logic [PTR_W-1:0] wptr_d  [NSRC];
  logic [PTR_W-1:0] rptr_q  [NSRC];
  logic [PTR_W-1:0] rptr_d  [NSRC];

  logic [XLEN-1:0]  mem_result_q [NSRC][FIFO_DEPTH];
  logic [3:0]       mem_tag_q    [NSRC][FIFO_DEPTH];

  logic [NSRC-1:0]  push;
  logic [NSRC-1:0]  nonempty;
  logic [NSRC-1:0]  starved;
  logic [NSRC-1:0]  grant;
  logic [2:0]       gnt_id;
  logic             gnt_any;

  logic             cdb_valid_q, cdb_valid_d;
  logic [XLEN-1:0]  cdb_result_q, cdb_result_d;
  logic [7:0]       cdb_tag_q, cdb_tag_d;

`ifdef CDB_STARVE_GUARD_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  logic [7:0] wait_cnt_q [NSRC];
  logic [7:0] wait_cnt_d [NSRC];
`endif

  // Ready depends only on occupancy and flush so producers never see a loop through src_valid.
  always_comb begin
    fifo_count = '0;
    for (int i = 0; i < NSRC; i++) begin
      nonempty[i]   = (count_q[i] != '0);
      src_ready[i]  = (count_q[i] < DEPTH_C) && !flush;
      push[i]       = src_valid[i] && src_ready[i];
      fifo_count[i*3 +: 3] = 3'(count_q[i]);
`ifdef CDB_STARVE_GUARD_EN
      starved[i]    = (wait_cnt_q[i] == LIMIT);
`else
      starved[i]    = 1'b0;
`endif
    end
  end

  // Descending scans let the lowest index overwrite; the starved pass overrides the plain pass.
  always_comb begin
    gnt_id  = '0;
    gnt_any = |nonempty;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (nonempty[i]) gnt_id = 3'(i);
    end
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (nonempty[i] && starved[i]) gnt_id = 3'(i);
    end
    grant = gnt_any ? (5'b00001 << gnt_id) : '0;
  end

  always_comb begin
    cdb_valid_d  = 1'b0;
    cdb_result_d = cdb_result_q;
    cdb_tag_d    = cdb_tag_q;
    for (int i = 0; i < NSRC; i++) begin
      count_d[i] = count_q[i];
      wptr_d[i]  = wptr_q[i];
      rptr_d[i]  = rptr_q[i];
`ifdef CDB_STARVE_GUARD_EN
      wait_cnt_d[i] = wait_cnt_q[i];
`endif
    end

    if (flush) begin
      for (int i = 0; i < NSRC; i++) begin
        count_d[i] = '0;
        wptr_d[i]  = '0;
        rptr_d[i]  = '0;
`ifdef CDB_STARVE_GUARD_EN
        wait_cnt_d[i] = '0;
`endif
      end
    end else begin
      if (gnt_any) begin
        cdb_valid_d  = 1'b1;
        cdb_result_d = mem_result_q[gnt_id][rptr_q[gnt_id]];
        cdb_tag_d    = {1'b0, gnt_id, mem_tag_q[gnt_id][rptr_q[gnt_id]]};
      end
      for (int i = 0; i < NSRC; i++) begin
        count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(grant[i]);
        if (push[i])  wptr_d[i] = wptr_q[i] + PTR_W'(1);
        if (grant[i]) rptr_d[i] = rptr_q[i] + PTR_W'(1);
`ifdef CDB_STARVE_GUARD_EN
        if (!nonempty[i] || grant[i]) begin
          wait_cnt_d[i] = '0;
        end else if (wait_cnt_q[i] < LIMIT) begin
          wait_cnt_d[i] = wait_cnt_q[i] + 8'd1;
        end
`endif
      end
    end
  end

  // Entry storage needs no reset: occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (push[i]) begin
        mem_result_q[i][wptr_q[i]] <= src_result[i*XLEN +: XLEN];
        mem_tag_q[i][wptr_q[i]]    <= 4'(src_tag[i*TAG_W +: TAG_W]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q  <= 1'b0;
      cdb_result_q <= '0;
      cdb_tag_q    <= '0;
      for (int i = 0; i < NSRC; i++) begin
        count_q[i] <= '0;
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
`ifdef CDB_STARVE_GUARD_EN
        wait_cnt_q[i] <= '0;
`endif
      end
    end else begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_result_q <= cdb_result_d;
      cdb_tag_q    <= cdb_tag_d;
      for (int i = 0; i < NSRC; i++) begin
        count_q[i] <= count_d[i];
        wptr_q[i]  <= wptr_d[i];
        rptr_q[i]  <= rptr_d[i];
`ifdef CDB_STARVE_GUARD_EN
        wait_cnt_q[i] <= wait_cnt_d[i];
`endif
      end
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_result = cdb_result_q;
  assign cdb_tag    = cdb_tag_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized self-checking bench for cdb_arbiter against a queue-based model
module tb_cdb_arbiter;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic [4:0]         src_valid;
  logic [4:0]         src_ready;
  logic [5*XLEN-1:0]  src_result;
  logic [5*TAG_W-1:0] src_tag;
  logic               cdb_valid;
  logic [XLEN-1:0]    cdb_result;
  logic [7:0]         cdb_tag;
  logic [14:0]        fifo_count;

  always #5 clk = ~clk;

  cdb_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_result(src_result), .src_tag(src_tag),
    .cdb_valid(cdb_valid), .cdb_result(cdb_result), .cdb_tag(cdb_tag),
    .fifo_count(fifo_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Reference model: one queue of {result, tag} per source plus per-source wait counts.
  logic [35:0] mq [5][$];
  int          mwait [5];
  logic        m_valid;
  logic [31:0] m_result;
  logic [7:0]  m_tag;
  logic [31:0] d_res [5];
  logic [3:0]  d_tag [5];

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      mq[i].delete();
      mwait[i] = 0;
    end
    m_valid  = 1'b0;
    m_result = '0;
    m_tag    = '0;
  endtask

  function automatic int busy();
    int n = 0;
    for (int i = 0; i < 5; i++) n += mq[i].size();
    return n;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < 5; i++) begin
      d_res[i] = $urandom;
      d_tag[i] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic drive(input logic [4:0] v, input logic f);
    src_valid = v;
    flush     = f;
    for (int i = 0; i < 5; i++) begin
      src_result[i*XLEN +: XLEN] = d_res[i];
      src_tag[i*TAG_W +: TAG_W]  = d_tag[i];
    end
  endtask

  task automatic step(input logic [4:0] v, input logic f);
    logic [4:0]  exp_rdy;
    logic [4:0]  ne;
    logic [14:0] exp_cnt;
    logic [35:0] e;
    int g;
    drive(v, f);
    #1;
    for (int i = 0; i < 5; i++) exp_rdy[i] = (mq[i].size() < DEPTH) && !f;
    check("src_ready", src_ready, exp_rdy);
    @(posedge clk);
    #1;
    if (f) begin
      for (int i = 0; i < 5; i++) begin
        mq[i].delete();
        mwait[i] = 0;
      end
      m_valid = 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) ne[i] = (mq[i].size() > 0);
      g = -1;
`ifdef CDB_STARVE_GUARD_EN
      for (int i = 0; i < 5 && g < 0; i++) if (ne[i] && mwait[i] == LIMIT) g = i;
`endif
      for (int i = 0; i < 5 && g < 0; i++) if (ne[i]) g = i;
      m_valid = (g >= 0);
      if (g >= 0) begin
        e        = mq[g].pop_front();
        m_result = e[35:4];
        m_tag    = {1'b0, 3'(g), e[3:0]};
      end
      for (int i = 0; i < 5; i++) begin
        if (!ne[i] || g == i) mwait[i] = 0;
        else if (mwait[i] < LIMIT) mwait[i] = mwait[i] + 1;
        if (exp_rdy[i] && v[i]) mq[i].push_back({d_res[i], d_tag[i]});
      end
    end
    for (int i = 0; i < 5; i++) exp_cnt[i*3 +: 3] = 3'(mq[i].size());
    check("cdb_valid", cdb_valid, m_valid);
    check("cdb_result", cdb_result, m_result);
    check("cdb_tag", cdb_tag, m_tag);
    check("fifo_count", fifo_count, exp_cnt);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && busy() > 0; k++) step(5'b00000, 1'b0);
    check("drain_empty", fifo_count, 15'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int div_at;
    int seen_full;
    int bad;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d_res[i] = '0;
      d_tag[i] = '0;
    end
    drive(5'b00000, 1'b0);
    model_reset();
    #1;
    check("rst_valid", cdb_valid, 1'b0);
    check("rst_result", cdb_result, 32'd0);
    check("rst_tag", cdb_tag, 8'd0);
    check("rst_count", fifo_count, 15'd0);
    check("rst_ready", src_ready, 5'b11111);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Single ALU result
    d_res[0] = 32'h0000_00AA;
    d_tag[0] = 4'd3;
    step(5'b00001, 1'b0);
    check("single_e0_valid", cdb_valid, 1'b0);
    step(5'b00000, 1'b0);
    check("single_e1_valid", cdb_valid, 1'b1);
    check("single_e1_result", cdb_result, 32'h0000_00AA);
    check("single_e1_tag", cdb_tag, 8'h03);
    step(5'b00000, 1'b0);
    check("single_e2_valid", cdb_valid, 1'b0);

    // ALU, MUL, VEU together
    rand_data();
    step(5'b10101, 1'b0);
    step(5'b00000, 1'b0);
    check("order_0_src", cdb_tag[6:4], 3'd0);
    step(5'b00000, 1'b0);
    check("order_1_src", cdb_tag[6:4], 3'd2);
    step(5'b00000, 1'b0);
    check("order_2_src", cdb_tag[6:4], 3'd4);
    step(5'b00000, 1'b0);
    check("order_idle_valid", cdb_valid, 1'b0);

    // LSU streaming against a streaming ALU fills the LSU buffer
    seen_full = 0;
    for (int k = 0; k < 14; k++) begin
      rand_data();
      step(5'b00011, 1'b0);
      if (fifo_count[5:3] == 3'd2) seen_full = 1;
    end
    check("lsu_full_seen", seen_full, 1);
    drain();

    // DIV waits behind a saturating ALU
    rand_data();
    step(5'b00001, 1'b0);
    rand_data();
    step(5'b00001, 1'b0);
    rand_data();
    d_tag[3] = 4'hD;
    step(5'b01001, 1'b0);
    div_at = -1;
    for (int n = 1; n <= 20; n++) begin
      rand_data();
      step(5'b00001, 1'b0);
      if (div_at < 0 && cdb_valid && cdb_tag[6:4] == 3'd3) div_at = n;
    end
`ifdef CDB_STARVE_GUARD_EN
    check("div_starve_latency", div_at, 9);
`else
    check("div_never_granted", div_at, -1);
`endif
    drain();

    // Flush with MUL and DIV holding two entries each
    for (int k = 0; k < 2; k++) begin
      rand_data();
      step(5'b01101, 1'b0);
    end
    check("pre_flush_mul", fifo_count[8:6], 3'd2);
    check("pre_flush_div", fifo_count[11:9], 3'd2);
    rand_data();
    step(5'b01101, 1'b1);
    check("flush_count", fifo_count, 15'd0);
    check("flush_valid", cdb_valid, 1'b0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      step(5'b00000, 1'b0);
      if (cdb_valid && (cdb_tag[6:4] == 3'd2 || cdb_tag[6:4] == 3'd3)) bad++;
    end
    check("flush_no_muldiv", bad, 0);

    // Asynchronous reset in the middle of a burst
    for (int k = 0; k < 3; k++) begin
      rand_data();
      step(5'b11111, 1'b0);
    end
    check("burst_valid", cdb_valid, 1'b1);
    drive(5'b00000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", cdb_valid, 1'b0);
    check("midrst_result", cdb_result, 32'd0);
    check("midrst_tag", cdb_tag, 8'd0);
    check("midrst_count", fifo_count, 15'd0);
    check("midrst_ready", src_ready, 5'b11111);
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    rand_data();
    d_res[2] = 32'hC0DE_0001;
    d_tag[2] = 4'h5;
    step(5'b00100, 1'b0);
    check("postrst_idle", cdb_valid, 1'b0);
    step(5'b00000, 1'b0);
    check("postrst_valid", cdb_valid, 1'b1);
    check("postrst_result", cdb_result, 32'hC0DE_0001);
    check("postrst_tag", cdb_tag, 8'h25);

    // Random traffic with occasional flushes
    for (int k = 0; k < 400; k++) begin
      logic [4:0] v;
      rand_data();
      v = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0) v = v & 5'($urandom_range(0, 31));
      step(v, $urandom_range(0, 39) == 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
